// File: rtl/div_req_queue.sv
// Request FIFO in front of the serial divider: buffers div/rem requests and hands them off as
// single-cycle registered pulses. Define DIV_QUEUE_BYPASS_EN for a 1-cycle empty-queue bypass.
module div_req_queue #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         req_vld_i,
  output logic                         req_rdy_o,
  input  logic [TRANS_ID_BITS-1:0]     req_id_i,
  input  logic [WIDTH-1:0]             req_op_a_i,
  input  logic [WIDTH-1:0]             req_op_b_i,
  input  logic [1:0]                   req_opcode_i,
  output logic                         div_vld_o,
  input  logic                         div_rdy_i,
  output logic [TRANS_ID_BITS-1:0]     div_id_o,
  output logic [WIDTH-1:0]             div_op_a_o,
  output logic [WIDTH-1:0]             div_op_b_o,
  output logic [1:0]                   div_opcode_o,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [WIDTH-1:0]         op_a;
    logic [WIDTH-1:0]         op_b;
    logic [1:0]               opcode;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          req_entry;
  entry_t          pay_q;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            div_vld_q;
  logic            rdy_q;
  logic            push, store, issue, bypass;

  assign req_entry = '{id: req_id_i, op_a: req_op_a_i, op_b: req_op_b_i, opcode: req_opcode_i};

  assign req_rdy_o = (count_q < CntW'(DEPTH)) & ~flush_i;
  assign push      = req_vld_i & req_rdy_o;
  assign issue     = (count_q != '0) & rdy_q & ~div_vld_q & ~flush_i;

`ifdef DIV_QUEUE_BYPASS_EN
  // Empty queue and idle divider: skip storage and hand the request over directly.
  assign bypass = push & (count_q == '0) & rdy_q & ~div_vld_q;
`else
  assign bypass = 1'b0;
`endif

  assign store = push & ~bypass;

  always_comb begin
    count_d = count_q;
    if (store && !issue) begin
      count_d = count_q + CntW'(1);
    end else if (issue && !store) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      div_vld_q <= 1'b0;
      rdy_q     <= 1'b0;
      pay_q     <= '0;
    end else if (flush_i) begin
      // Payload registers deliberately keep their value across a flush.
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      div_vld_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      div_vld_q <= issue | bypass;
      rdy_q     <= div_rdy_i & ~div_vld_q;
      if (store) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        pay_q    <= mem_q[rd_ptr_q];
      end else if (bypass) begin
        pay_q    <= req_entry;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      mem_q[wr_ptr_q] <= req_entry;
    end
  end

  assign div_vld_o    = div_vld_q;
  assign div_id_o     = pay_q.id;
  assign div_op_a_o   = pay_q.op_a;
  assign div_op_b_o   = pay_q.op_b;
  assign div_opcode_o = pay_q.opcode;
  assign busy_o       = (count_q != '0) | div_vld_q;
  assign count_o      = count_q;

endmodule

// File: tb/tb_div_req_queue.sv
// Bench for div_req_queue: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations and a randomized phase.
module tb_div_req_queue;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned TIDW  = 3;
`ifdef DIV_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [TIDW-1:0]  id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
  } req_t;

  logic             clk = 1'b0;
  logic             rst_ni, flush_i, req_vld_i, req_rdy_o, div_vld_o, div_rdy_i, busy_o;
  logic [TIDW-1:0]  req_id_i, div_id_o;
  logic [WIDTH-1:0] req_op_a_i, req_op_b_i, div_op_a_o, div_op_b_o;
  logic [1:0]       req_opcode_i, div_opcode_o;
  logic [1:0]       count_o;

  int checks = 0;
  int fails  = 0;

  req_t            mq[$];
  req_t            m_pay;
  logic            m_vld, m_rdy;
  logic [TIDW-1:0] issued[$];

  div_req_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TRANS_ID_BITS(TIDW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_id_i(req_id_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_opcode_i(req_opcode_i),
    .div_vld_o(div_vld_o), .div_rdy_i(div_rdy_i), .div_id_o(div_id_o),
    .div_op_a_o(div_op_a_o), .div_op_b_o(div_op_b_o), .div_opcode_o(div_opcode_o),
    .busy_o(busy_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a FIFO of pending requests plus the handoff rules.
  initial forever begin
    @(posedge clk or negedge rst_ni);
    if (!rst_ni) begin
      mq.delete();
      m_vld = 1'b0;
      m_rdy = 1'b0;
      m_pay = '0;
    end else if (flush_i) begin
      mq.delete();
      m_vld = 1'b0;
      m_rdy = 1'b0;
    end else begin
      logic acc, nvld, used;
      req_t r;
      r    = '{id: req_id_i, a: req_op_a_i, b: req_op_b_i, op: req_opcode_i};
      acc  = req_vld_i && (mq.size() < DEPTH);
      nvld = 1'b0;
      used = 1'b0;
`ifdef DIV_QUEUE_BYPASS_EN
      if (acc && mq.size() == 0 && m_rdy && !m_vld) begin
        m_pay = r;
        nvld  = 1'b1;
        used  = 1'b1;
      end
`endif
      if (!used && mq.size() != 0 && m_rdy && !m_vld) begin
        m_pay = mq.pop_front();
        nvld  = 1'b1;
      end
      if (acc && !used) mq.push_back(r);
      m_rdy = div_rdy_i && !m_vld;
      m_vld = nvld;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst_ni) begin
      chk("vld", div_vld_o, m_vld);
      chk("count", count_o, mq.size());
      chk("req_rdy", req_rdy_o, (mq.size() < DEPTH) && !flush_i);
      chk("busy", busy_o, (mq.size() != 0) || m_vld);
      chk("payload", {div_id_o, div_op_a_o, div_op_b_o, div_opcode_o}, m_pay);
      if (div_vld_o) issued.push_back(div_id_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [TIDW-1:0] id, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] op);
    req_id_i     = id;
    req_op_a_i   = a;
    req_op_b_i   = b;
    req_opcode_i = op;
  endtask

  task automatic push_one(input logic [TIDW-1:0] id);
    int n = 0;
    set_req(id, 64'($urandom), 64'($urandom), 2'($urandom_range(0, 3)));
    req_vld_i = 1'b1;
    while (!req_rdy_o && n < 100) begin
      step();
      n++;
    end
    chk("push_timeout", n < 100, 1);
    step();
    req_vld_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (busy_o && n < 200) begin
      step();
      n++;
    end
    chk("drain_timeout", n < 200, 1);
    step();
  endtask

  task automatic wait_vld();
    int n = 0;
    while (!div_vld_o && n < 50) begin
      step();
      n++;
    end
    chk("vld_timeout", n < 50, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; req_vld_i = 1'b0; div_rdy_i = 1'b1;
    set_req('0, '0, '0, '0);
    step(); step();
    chk("rst_req_rdy", req_rdy_o, 1);
    chk("rst_vld", div_vld_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_op_a", div_op_a_o, 0);
    rst_ni = 1'b1;
    step(); step(); step();

    // 1: single request, idle divider
    set_req(3'd3, 64'd100, 64'd7, 2'd0);
    req_vld_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      req_vld_i = 1'b0;
      chk("t1_vld", div_vld_o, k == LAT);
      if (k == LAT) begin
        chk("t1_id", div_id_o, 3);
        chk("t1_a", div_op_a_o, 100);
        chk("t1_b", div_op_b_o, 7);
        chk("t1_op", div_opcode_o, 0);
      end
    end

    // 2/3: fill with divider busy, then one-cycle ready pulse while 3rd request waits
    div_rdy_i = 1'b0;
    step(); step(); step();
    issued.delete();
    push_one(3'd1);
    push_one(3'd2);
    chk("t2_count", count_o, 2);
    chk("t2_rdy", req_rdy_o, 0);
    set_req(3'd3, 64'd33, 64'd3, 2'd3);
    req_vld_i = 1'b1;
    step(); step();
    chk("t2_held", count_o, 2);
    div_rdy_i = 1'b1;
    step();
    div_rdy_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (req_rdy_o) begin
        step();
        req_vld_i = 1'b0;
      end else step();
    end
    req_vld_i = 1'b0;
    div_rdy_i = 1'b1;
    drain();
    chk("t3_n", issued.size(), 3);
    for (int i = 0; i < 3 && i < issued.size(); i++) chk("t3_order", issued[i], i + 1);

    // 4: flush during handoff
    div_rdy_i = 1'b0;
    step(); step(); step();
    push_one(3'd4);
    push_one(3'd5);
    set_req(3'd6, 64'd6, 64'd6, 2'd1);
    req_vld_i = 1'b1;
    div_rdy_i = 1'b1;
    wait_vld();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    req_vld_i = 1'b0;
    chk("t4_count", count_o, 0);
    chk("t4_vld", div_vld_o, 0);
    chk("t4_busy", busy_o, 0);
    issued.delete();
    for (int k = 0; k < 5; k++) step();
    chk("t4_no_issue", issued.size(), 0);

    // 5: pointer wrap
    issued.delete();
    for (int i = 0; i < 5; i++) push_one(3'(i));
    drain();
    chk("t5_n", issued.size(), 5);
    for (int i = 0; i < 5 && i < issued.size(); i++) chk("t5_order", issued[i], i);

    // 6: asynchronous reset mid-operation
    div_rdy_i = 1'b0;
    step(); step(); step();
    push_one(3'd7);
    push_one(3'd0);
    set_req(3'd2, 64'd2, 64'd2, 2'd2);
    req_vld_i = 1'b1;
    div_rdy_i = 1'b1;
    wait_vld();
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_vld", div_vld_o, 0);
    chk("t6_count", count_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_id", div_id_o, 0);
    chk("t6_op_a", div_op_a_o, 0);
    req_vld_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    chk("t6_req_rdy", req_rdy_o, 1);

    // Randomized phase
    for (int k = 0; k < 600; k++) begin
      flush_i   = ($urandom_range(0, 29) == 0);
      req_vld_i = 1'($urandom_range(0, 1));
      div_rdy_i = ($urandom_range(0, 3) != 0);
      set_req(3'($urandom), {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
              2'($urandom_range(0, 3)));
      step();
    end
    flush_i = 1'b0;
    req_vld_i = 1'b0;
    div_rdy_i = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
